// File: rtl/split_seq_multiplier.sv
// Multi-cycle WIDTHxWIDTH signed/unsigned multiplier that reuses one half-width
// Dadda core over the four operand quadrants, with valid/ready handshakes.

module DaddaMultiplier #(
    parameter int N = 16
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    localparam int COLS   = 2 * N;
    localparam int NSTAGE = 12;

    logic         bits       [COLS][N];
    logic         nextBits   [COLS][N];
    int           height     [COLS];
    int           nextHeight [COLS];
    int           dSeq       [NSTAGE];
    int           total;
    int           pos;
    logic [COLS-1:0] rowA;
    logic [COLS-1:0] rowB;

    // Column-wise Dadda reduction: each stage squeezes every column down to the next
    // target height, carries ripple into the following column of the same stage.
    always_comb begin
        bits       = '{default: '{default: 1'b0}};
        nextBits   = '{default: '{default: 1'b0}};
        height     = '{default: 0};
        nextHeight = '{default: 0};
        total      = 0;
        pos        = 0;
        rowA       = '0;
        rowB       = '0;

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                bits[i+j][height[i+j]] = a[j] & b[i];
                height[i+j]++;
            end
        end

        dSeq[0] = 2;
        for (int k = 1; k < NSTAGE; k++) begin
            dSeq[k] = (dSeq[k-1] * 3) / 2;
        end

        for (int s = NSTAGE - 1; s >= 0; s--) begin
            if (dSeq[s] < N) begin
                nextBits   = '{default: '{default: 1'b0}};
                nextHeight = '{default: 0};
                for (int c = 0; c < COLS; c++) begin
                    total = height[c] + nextHeight[c];
                    pos   = 0;
                    for (int k = 0; k < N; k++) begin
                        if (total > dSeq[s]) begin
                            if (total - dSeq[s] >= 2) begin
                                nextBits[c][nextHeight[c]] = bits[c][pos] ^ bits[c][pos+1] ^ bits[c][pos+2];
                                nextHeight[c]++;
                                if (c + 1 < COLS) begin
                                    nextBits[c+1][nextHeight[c+1]] = (bits[c][pos] & bits[c][pos+1]) |
                                                                     (bits[c][pos] & bits[c][pos+2]) |
                                                                     (bits[c][pos+1] & bits[c][pos+2]);
                                    nextHeight[c+1]++;
                                end
                                pos   = pos + 3;
                                total = total - 2;
                            end else begin
                                nextBits[c][nextHeight[c]] = bits[c][pos] ^ bits[c][pos+1];
                                nextHeight[c]++;
                                if (c + 1 < COLS) begin
                                    nextBits[c+1][nextHeight[c+1]] = bits[c][pos] & bits[c][pos+1];
                                    nextHeight[c+1]++;
                                end
                                pos   = pos + 2;
                                total = total - 1;
                            end
                        end
                    end
                    for (int k = 0; k < N; k++) begin
                        if (k >= pos && k < height[c]) begin
                            nextBits[c][nextHeight[c]] = bits[c][k];
                            nextHeight[c]++;
                        end
                    end
                end
                bits   = nextBits;
                height = nextHeight;
            end
        end

        for (int c = 0; c < COLS; c++) begin
            rowA[c] = bits[c][0];
            rowB[c] = bits[c][1];
        end
        p = rowA + rowB;
    end

endmodule

module split_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} stateType;

    stateType           state;
    stateType           nextState;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               neg;
    logic [1:0]         idx;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] shiftedProd;
    logic [2*WIDTH-1:0] outReg;
    logic [HALF-1:0]    coreA;
    logic [HALF-1:0]    coreB;
    logic [WIDTH-1:0]   coreP;

    // The most negative operand negates onto itself, which is exactly its unsigned magnitude.
    assign absA = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
    assign absB = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;

    // idx bit 0 picks the high half of A, bit 1 the high half of B.
    assign coreA = idx[0] ? magA[WIDTH-1:HALF] : magA[HALF-1:0];
    assign coreB = idx[1] ? magB[WIDTH-1:HALF] : magB[HALF-1:0];

    DaddaMultiplier #(.N(HALF)) core (
        .a(coreA),
        .b(coreB),
        .p(coreP)
    );

    always_comb begin
        shiftedProd = '0;
        case (idx)
            2'd0:    shiftedProd = {{WIDTH{1'b0}}, coreP};
            2'd3:    shiftedProd = {coreP, {WIDTH{1'b0}}};
            default: shiftedProd = {{HALF{1'b0}}, coreP, {HALF{1'b0}}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid) nextState = CALC;
            CALC:    if (idx == 2'd3) nextState = SIGN;
            SIGN:    nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            magA   <= '0;
            magB   <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            idx    <= '0;
            outReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        magA <= absA;
                        magB <= absB;
                        neg  <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + shiftedProd;
                    idx <= idx + 2'd1;
                end
                SIGN:    outReg <= neg ? (~acc + 1'b1) : acc;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_p     = outReg;

endmodule

// File: tb/tb_split_seq_multiplier.sv
// Randomised and directed self-check of split_seq_multiplier (WIDTH=32 and WIDTH=8)
// against a plain-arithmetic product model.

module tb_split_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inSigned, outReady;
    logic [31:0] inA, inB;
    logic        inReady, outValid, busy;
    logic [63:0] outP;
    logic        inValid8, inSigned8, outReady8;
    logic [7:0]  inA8, inB8;
    logic        inReady8, outValid8, busy8;
    logic [15:0] outP8;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    split_seq_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB),
        .in_signed(inSigned), .out_valid(outValid), .out_ready(outReady), .out_p(outP), .busy(busy)
    );

    split_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8), .in_a(inA8), .in_b(inB8),
        .in_signed(inSigned8), .out_valid(outValid8), .out_ready(outReady8), .out_p(outP8), .busy(busy8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({32'b0, a}) * longint'({32'b0, b});
        return p;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'({24'b0, a}) * int'({24'b0, b});
        return p[15:0];
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   input int stall, input string tag);
        logic [63:0] expected;
        int lat;
        expected = model32(a, b, s);
        inA = a; inB = b; inSigned = s; inValid = 1'b1; outReady = (stall == 0);
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "Lat"}, 64'(lat), 64'd5);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
        end
        outReady = 1'b1;
        checkOutput({tag, "Valid"}, 64'(outValid), 64'd1);
        checkOutput({tag, "P"}, outP, expected);
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput({tag, "Drop"}, 64'(outValid), 64'd0);
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  input int stall, input string tag);
        logic [15:0] expected;
        int lat;
        expected = model8(a, b, s);
        inA8 = a; inB8 = b; inSigned8 = s; inValid8 = 1'b1; outReady8 = (stall == 0);
        @(posedge clk); #1;
        inValid8 = 1'b0;
        lat = 0;
        while (!outValid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "Lat"}, 64'(lat), 64'd5);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
        end
        outReady8 = 1'b1;
        checkOutput({tag, "P"}, 64'(outP8), 64'(expected));
        @(posedge clk); #1;
        outReady8 = 1'b0;
        checkOutput({tag, "Drop"}, 64'(outValid8), 64'd0);
    endtask

    initial begin
        logic [63:0] heldP;
        logic        seenValid;
        logic [7:0]  opA [3];
        logic [7:0]  opB [3];
        logic        opS [3];
        logic [15:0] results [3];
        int          acceptEdge [3];
        int          consumeEdge [3];
        int          opIdx, resCount, lat;
        logic        acceptNow;

        rst = 1'b1;
        inValid = 1'b0; inA = '0; inB = '0; inSigned = 1'b0; outReady = 1'b0;
        inValid8 = 1'b0; inA8 = '0; inB8 = '0; inSigned8 = 1'b0; outReady8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReady", 64'(inReady), 64'd1);
        checkOutput("rstValid", 64'(outValid), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstP", outP, 64'd0);
        rst = 1'b0;

        applyStimulus32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "maxU");
        applyStimulus32(32'h80000000, 32'h80000000, 1'b1, 0, "minS");
        applyStimulus32(32'hFFFFFFFD, 32'd5, 1'b1, 0, "negS");

        // Backpressure: DONE must hold steady and ignore a stray in_valid pulse.
        inA = 32'h1234; inB = 32'h10; inSigned = 1'b0; inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        heldP = model32(32'h1234, 32'h10, 1'b0);
        for (int k = 0; k < 10; k++) begin
            checkOutput("bpValid", 64'(outValid), 64'd1);
            checkOutput("bpReady", 64'(inReady), 64'd0);
            checkOutput("bpBusy", 64'(busy), 64'd1);
            checkOutput("bpP", outP, heldP);
            if (k == 3) begin
                inA = 32'd7; inB = 32'd9; inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("bpIdleReady", 64'(inReady), 64'd1);
        checkOutput("bpIdleValid", 64'(outValid), 64'd0);
        applyStimulus32(32'd7, 32'd9, 1'b0, 0, "afterBp");

        // Reset while CALC is on its third quadrant.
        inA = 32'h1234; inB = 32'h5678; inSigned = 1'b0; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midRstReady", 64'(inReady), 64'd1);
        checkOutput("midRstValid", 64'(outValid), 64'd0);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstP", outP, 64'd0);
        rst = 1'b0;
        seenValid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (outValid) seenValid = 1'b1;
        end
        checkOutput("midRstNoEmit", 64'(seenValid), 64'd0);
        outReady = 1'b0;
        applyStimulus32(32'd3, 32'd4, 1'b0, 0, "postRst");

        // Back-to-back stream on the narrow instance with in_valid held high.
        opA[0] = 8'hFF; opB[0] = 8'hFF; opS[0] = 1'b0;
        opA[1] = 8'hFF; opB[1] = 8'hFF; opS[1] = 1'b1;
        opA[2] = 8'h80; opB[2] = 8'h7F; opS[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            results[k] = '0; acceptEdge[k] = 0; consumeEdge[k] = 0;
        end
        opIdx = 0; resCount = 0;
        inA8 = opA[0]; inB8 = opB[0]; inSigned8 = opS[0]; inValid8 = 1'b1; outReady8 = 1'b1;
        for (int cyc = 0; cyc < 80 && resCount < 3; cyc++) begin
            acceptNow = inValid8 && inReady8;
            if (outValid8) begin
                results[resCount]     = outP8;
                consumeEdge[resCount] = cyc + 1;
                resCount++;
            end
            @(posedge clk); #1;
            if (acceptNow) begin
                acceptEdge[opIdx] = cyc + 1;
                opIdx++;
                if (opIdx < 3) begin
                    inA8 = opA[opIdx]; inB8 = opB[opIdx]; inSigned8 = opS[opIdx];
                end else begin
                    inValid8 = 1'b0;
                end
            end
        end
        inValid8 = 1'b0;
        outReady8 = 1'b0;
        checkOutput("b2bCount", 64'(resCount), 64'd3);
        checkOutput("b2bP0", 64'(results[0]), 64'h0000_0000_0000_FE01);
        checkOutput("b2bP1", 64'(results[1]), 64'h0000_0000_0000_0001);
        checkOutput("b2bP2", 64'(results[2]), 64'h0000_0000_0000_C080);
        for (int k = 0; k < 3; k++) begin
            checkOutput("b2bResidence", 64'(consumeEdge[k] - acceptEdge[k]), 64'd6);
        end
        for (int k = 0; k < 2; k++) begin
            checkOutput("b2bNextAccept", 64'(acceptEdge[k+1]), 64'(consumeEdge[k] + 1));
        end

        for (int i = 0; i < 1500; i++) begin
            applyStimulus32(pick32(), pick32(), 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "rand32");
        end
        for (int i = 0; i < 1500; i++) begin
            applyStimulus8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "rand8");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
